i2c_event_timestamper: RTL
==========================

// Module: i2c_event_timestamper
// PURPOSE
//  Sequences the 1us time counter for the I2C monitor: holds it in reset while the bus is idle, runs it during a
//  transaction, and captures the elapsed time at every decoded bus event. Each event becomes one record
//  {type, ack, lost, byte, delta-time} in a 2-entry buffer, drained by a valid/ready consumer (UART formatter).
//  Sits between the I2C bit decoder (events in), the time counter (control out, value in) and the output path.
// PARAMETERS
//  TS_W   32  width of captured time value; must equal the time counter width
//  DROP_W 8   width of the saturating dropped-record counter
// PORTS
//  i_clk        in  1        system clock (24MHz)
//  i_res        in  1        synchronous reset, active-high
//  i_arm        in  1        monitor enable; 0 forces IDLE
//  i_start      in  1        1-cycle pulse: START/repeated START detected
//  i_stop       in  1        1-cycle pulse: STOP detected
//  i_byte_vld   in  1        1-cycle pulse: byte + ACK bit complete
//  i_byte       in  8        received byte, valid with i_byte_vld
//  i_ack        in  1        ACK bit (0=ACK, 1=NACK), valid with i_byte_vld
//  o_cnt_res    out 1        time counter synchronous clear
//  o_cnt_en     out 1        time counter enable
//  i_cnt_val    in  TS_W     time counter value (us, saturating)
//  o_rec_valid  out 1        record available
//  i_rec_ready  in  1        consumer accepts record when valid&ready
//  o_rec_data   out TS_W+16  {type[1:0], ack, lost, 4'b0, byte[7:0], delta[TS_W-1:0]}
//  o_drop_cnt   out DROP_W   records dropped on full buffer, saturates at all-ones
// BEHAVIOUR
//  - Reset (i_res=1): state IDLE, buffer empty, pending=0, lost flag=0; o_cnt_res=1, o_cnt_en=0, o_rec_valid=0,
//    o_rec_data=0, o_drop_cnt=0. Reset mid-transaction discards buffered records.
//  - Record types: 2'b00 START, 2'b01 RSTART, 2'b10 BYTE, 2'b11 STOP. ack/byte fields are 0 unless BYTE.
//  - FSM IDLE: o_cnt_en=0, o_cnt_res=1. i_arm & i_start -> record START, delta=0, go ACTIVE. i_stop/i_byte_vld ignored.
//  - FSM ACTIVE: o_cnt_en=1. Event at cycle N captures delta=i_cnt_val at N; o_cnt_res=1 at cycle N+1 only.
//    i_start -> RSTART, stay ACTIVE. i_byte_vld -> BYTE. i_stop -> STOP, go IDLE.
//  - i_arm=0: go IDLE next cycle from any state; pending event cleared; buffer contents kept and still drained.
//  - Simultaneous: i_byte_vld with i_start or i_stop in one cycle -> BYTE recorded at N, the start/stop held in a
//    1-deep pending register and recorded at N+1 with delta=0. i_start & i_stop together -> STOP wins, start ignored.
//    A new event arriving while pending is occupied: pending is recorded, new event counts as dropped.
//  - Buffer: 2-entry FIFO, write at end of event cycle; o_rec_valid=1 from N+1 when previously empty.
//    Read and write in the same cycle when full is allowed (no drop). Pop on o_rec_valid & i_rec_ready.
//  - Full on write: record dropped, o_drop_cnt+1 (saturating), lost flag set; next successfully written record
//    carries lost=1, which clears the flag. FSM transitions happen regardless of drop.
//  - delta is i_cnt_val unmodified; saturation is the counter's (all-ones stays all-ones).
// STRUCTURE
//  - Shared package i2cmon_pkg: event type constants (EV_START/EV_RSTART/EV_BYTE/EV_STOP), FSM state encodings,
//    record field offset localparams.
//  - One sub-module: ts_rec_fifo (2-entry, width TS_W+16, registered outputs, full/empty, simultaneous rd/wr).
//  - Top: FSM, pending register, counter control, record packing, drop counter.
// TESTING
//  - Reset: hold i_res 3 cycles -> o_cnt_res=1, o_cnt_en=0, o_rec_valid=0, o_drop_cnt=0; release, no events -> unchanged.
//  - i_start (armed) -> START rec delta=0; bench i_cnt_val=37, i_byte_vld byte=8'hA5 ack=0 -> BYTE rec delta=37,
//    byte=A5, o_cnt_res 1 at N+1 only; i_cnt_val=12, i_stop -> STOP rec delta=12, o_cnt_en=0 next cycle.
//  - i_rec_ready=0, START+2 BYTEs -> 2 stored, o_drop_cnt=1; ready=1 drains; next BYTE record has lost=1, following lost=0.
//  - i_byte_vld & i_stop same cycle, i_cnt_val=9 -> BYTE delta=9 then STOP delta=0 on consecutive writes, then IDLE.
//  - In ACTIVE i_start -> RSTART; in IDLE i_stop and i_byte_vld -> no record; i_start & i_stop same cycle -> STOP only.
//  - i_arm=0 mid-transaction -> IDLE, o_cnt_res=1, buffered records still delivered; i_res mid-drain -> buffer empty.

Source files
------------

// File: rtl/i2cmon_pkg.sv
// Shared definitions for the I2C monitor: event codes, FSM encodings and record header layout.
package i2cmon_pkg;

    typedef enum logic [1:0] {
        EV_START  = 2'b00,
        EV_RSTART = 2'b01,
        EV_BYTE   = 2'b10,
        EV_STOP   = 2'b11
    } ev_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Record header sits above the delta field: {type, ack, lost, 4'b0, byte}
    typedef struct packed {
        ev_t        ev;
        logic       ack;
        logic       lost;
        logic [3:0] rsvd;
        logic [7:0] data;
    } rec_hdr_t;

    localparam int unsigned REC_HDR_W = $bits(rec_hdr_t);

endpackage

// File: rtl/i2c_event_timestamper_if.sv
// Bus bundle for the event timestamper: decoder events, time counter link and record output.
interface i2c_event_timestamper_if #(
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DROP_W = 8
);
    logic              i_arm;
    logic              i_start;
    logic              i_stop;
    logic              i_byte_vld;
    logic [7:0]        i_byte;
    logic              i_ack;
    logic              o_cnt_res;
    logic              o_cnt_en;
    logic [TS_W-1:0]   i_cnt_val;
    logic              o_rec_valid;
    logic              i_rec_ready;
    logic [TS_W+15:0]  o_rec_data;
    logic [DROP_W-1:0] o_drop_cnt;

    modport master (
        output i_arm, i_start, i_stop, i_byte_vld, i_byte, i_ack, i_cnt_val, i_rec_ready,
        input  o_cnt_res, o_cnt_en, o_rec_valid, o_rec_data, o_drop_cnt
    );

    modport slave (
        input  i_arm, i_start, i_stop, i_byte_vld, i_byte, i_ack, i_cnt_val, i_rec_ready,
        output o_cnt_res, o_cnt_en, o_rec_valid, o_rec_data, o_drop_cnt
    );
endinterface

// File: rtl/ts_rec_fifo.sv
// Two-entry record FIFO; head entry is a register driven straight to the output.
module ts_rec_fifo #(
    parameter int unsigned W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         full,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] slot0, slot1, slot0_next, slot1_next;
    logic         v0, v1, v0_next, v1_next;

    // Pop shifts the tail into the head, then a write lands in the first free slot
    always_comb begin
        slot0_next = slot0;
        slot1_next = slot1;
        v0_next    = v0;
        v1_next    = v1;
        if (rd_en && v0) begin
            if (v1) begin
                slot0_next = slot1;
            end
            v0_next = v1;
            v1_next = 1'b0;
        end
        if (wr_en) begin
            if (!v0_next) begin
                slot0_next = wr_data;
                v0_next    = 1'b1;
            end else if (!v1_next) begin
                slot1_next = wr_data;
                v1_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
        end else begin
            slot0 <= slot0_next;
            slot1 <= slot1_next;
            v0    <= v0_next;
            v1    <= v1_next;
        end
    end

    assign full     = v1;
    assign rd_valid = v0;
    assign rd_data  = slot0;

endmodule

// File: rtl/i2c_event_timestamper.sv
// Sequences the I2C monitor time counter and turns decoded bus events into timestamped records.
module i2c_event_timestamper
    import i2cmon_pkg::*;
#(
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DROP_W = 8
) (
    input logic                    i_clk,
    input logic                    i_res,
    i2c_event_timestamper_if.slave bus
);

    localparam int unsigned REC_W = TS_W + REC_HDR_W;
    localparam int unsigned SUM_W = DROP_W + 1;

    logic [0:0]        state, state_next;
    logic              pend_vld, pend_vld_next;
    ev_t               pend_ev, pend_ev_next;
    logic              lost, lost_next;
    logic              cnt_res, cnt_res_next;
    logic              cnt_en, cnt_en_next;
    logic [DROP_W-1:0] drop_cnt, drop_cnt_next;
    logic [SUM_W-1:0]  drop_sum;
    logic [1:0]        drop_inc;

    logic              new_vld, new_pend;
    ev_t               new_ev, new_pend_ev;
    logic              new_ack;
    logic [7:0]        new_byte;
    logic [TS_W-1:0]   new_delta;

    logic              rec_want, wr_ok, pop;
    rec_hdr_t          rec_hdr;
    logic [TS_W-1:0]   rec_delta;
    logic              fifo_full, fifo_valid;
    logic [REC_W-1:0]  fifo_data;

    assign pop = fifo_valid && bus.i_rec_ready;

    // Next-state, event decode, pending slot, drop accounting and counter control
    always_comb begin
        state_next    = state;
        pend_vld_next = 1'b0;
        pend_ev_next  = pend_ev;
        new_vld       = 1'b0;
        new_ev        = EV_START;
        new_ack       = 1'b0;
        new_byte      = '0;
        new_delta     = '0;
        new_pend      = 1'b0;
        new_pend_ev   = EV_STOP;
        rec_want      = 1'b0;
        rec_hdr       = '0;
        rec_delta     = '0;
        drop_inc      = 2'd0;

        if (!bus.i_arm) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        new_vld    = 1'b1;
                        new_ev     = EV_START;
                        state_next = ST_ACTIVE;
                    end
                end
                default: begin
                    if (bus.i_byte_vld) begin
                        new_vld   = 1'b1;
                        new_ev    = EV_BYTE;
                        new_ack   = bus.i_ack;
                        new_byte  = bus.i_byte;
                        new_delta = bus.i_cnt_val;
                        if (bus.i_stop) begin
                            new_pend    = 1'b1;
                            new_pend_ev = EV_STOP;
                            state_next  = ST_IDLE;
                        end else if (bus.i_start) begin
                            new_pend    = 1'b1;
                            new_pend_ev = EV_RSTART;
                        end
                    end else if (bus.i_stop) begin
                        new_vld    = 1'b1;
                        new_ev     = EV_STOP;
                        new_delta  = bus.i_cnt_val;
                        state_next = ST_IDLE;
                    end else if (bus.i_start) begin
                        new_vld   = 1'b1;
                        new_ev    = EV_RSTART;
                        new_delta = bus.i_cnt_val;
                    end
                end
            endcase

            // A held start/stop owns this cycle's write slot; any fresh event is lost
            if (pend_vld) begin
                rec_want   = 1'b1;
                rec_hdr.ev = pend_ev;
                if (new_vld) begin
                    drop_inc = 2'd1;
                end
            end else begin
                rec_want      = new_vld;
                rec_hdr.ev    = new_ev;
                rec_hdr.ack   = new_ack;
                rec_hdr.data  = new_byte;
                rec_delta     = new_delta;
                pend_vld_next = new_pend;
                pend_ev_next  = new_pend_ev;
            end
        end

        rec_hdr.lost = lost;
        wr_ok        = rec_want && (!fifo_full || pop);
        if (rec_want && !wr_ok) begin
            drop_inc = drop_inc + 2'd1;
        end

        lost_next     = (wr_ok ? 1'b0 : lost) || (drop_inc != 2'd0);
        drop_sum      = {1'b0, drop_cnt} + SUM_W'(drop_inc);
        drop_cnt_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

        cnt_en_next  = (state_next == ST_ACTIVE);
        cnt_res_next = (state_next == ST_IDLE) || new_vld;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            pend_ev  <= EV_START;
            lost     <= 1'b0;
            cnt_res  <= 1'b1;
            cnt_en   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            pend_vld <= pend_vld_next;
            pend_ev  <= pend_ev_next;
            lost     <= lost_next;
            cnt_res  <= cnt_res_next;
            cnt_en   <= cnt_en_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    ts_rec_fifo #(
        .W(REC_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_res),
        .wr_en   (wr_ok),
        .wr_data ({rec_hdr, rec_delta}),
        .rd_en   (pop),
        .full    (fifo_full),
        .rd_valid(fifo_valid),
        .rd_data (fifo_data)
    );

    assign bus.o_cnt_res   = cnt_res;
    assign bus.o_cnt_en    = cnt_en;
    assign bus.o_rec_valid = fifo_valid;
    assign bus.o_rec_data  = fifo_data;
    assign bus.o_drop_cnt  = drop_cnt;

endmodule
